// File: rtl/fc_stream_host.sv
// Host-side streaming shim for a fully-connected layer: streams an N-element input
// vector out over tx, collects an M-element result over rx, and exposes the result buffer.
module fc_stream_host #(
    parameter int WIDTH = 16,
    parameter int N     = 6,
    parameter int M     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [$clog2(N)-1:0] load_addr,
    input  logic [WIDTH-1:0]     load_data,
    input  logic                 start,
    input  logic                 stall_tx,
    input  logic                 stall_rx,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [WIDTH-1:0]     tx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [WIDTH-1:0]     rx_data,
    input  logic [$clog2(M)-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(M);
    localparam int TW = AW + 1;
    localparam int CW = RW + 1;
    localparam logic [TW-1:0] N_T = TW'(N);
    localparam logic [CW-1:0] M_C = CW'(M);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t          state_reg, state_next;
    logic            tx_valid_reg, tx_valid_next;
    logic [TW-1:0]   tx_idx_reg, tx_idx_next;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [WIDTH-1:0] vec [N];
    logic [WIDTH-1:0] res [M];

    logic            active;
    logic            rx_fire;
    logic [TW-1:0]   tx_idx_inc;
    logic [CW-1:0]   rx_cnt_inc;

    assign active     = (state_reg == SEND) || (state_reg == RECV);
    assign rx_ready   = active && (rx_cnt_reg < M_C) && !stall_rx;
    assign rx_fire    = rx_valid && rx_ready;
    assign tx_idx_inc = tx_idx_reg + TW'(1);
    assign rx_cnt_inc = rx_cnt_reg + CW'(1);

    always_comb begin
        state_next    = state_reg;
        tx_valid_next = tx_valid_reg;
        tx_idx_next   = tx_idx_reg;
        rx_cnt_next   = rx_cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = SEND;
                    tx_idx_next   = '0;
                    rx_cnt_next   = '0;
                    tx_valid_next = 1'b0;
                end
            end
            SEND: begin
                if (rx_fire) rx_cnt_next = rx_cnt_inc;
                if (!tx_valid_reg) begin
                    if ((tx_idx_reg < N_T) && !stall_tx) tx_valid_next = 1'b1;
                end else if (tx_ready) begin
                    // Keep valid high across the edge so back-to-back elements flow at full rate
                    tx_idx_next   = tx_idx_inc;
                    tx_valid_next = (tx_idx_inc < N_T) && !stall_tx;
                    if (tx_idx_inc == N_T)
                        state_next = (rx_cnt_next == M_C) ? DONE : RECV;
                end
            end
            RECV: begin
                if (rx_fire) begin
                    rx_cnt_next = rx_cnt_inc;
                    if (rx_cnt_inc == M_C) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            tx_valid_reg <= 1'b0;
            tx_idx_reg   <= '0;
            rx_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            tx_valid_reg <= tx_valid_next;
            tx_idx_reg   <= tx_idx_next;
            rx_cnt_reg   <= rx_cnt_next;
        end
    end

    // Buffers carry no reset; writes are gated so reset still wins over load and rx
    always_ff @(posedge clk) begin
        if (!reset && load_en && !active && ({1'b0, load_addr} < N_T))
            vec[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && rx_fire)
            res[rx_cnt_reg[RW-1:0]] <= rx_data;
    end

    assign tx_valid = tx_valid_reg;
    assign tx_data  = (tx_idx_reg < N_T) ? vec[tx_idx_reg[AW-1:0]] : '0;
    assign rd_data  = ({1'b0, rd_addr} < M_C) ? res[rd_addr] : '0;
    assign busy     = active;
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_fc_stream_host.sv
// Scoreboard bench for fc_stream_host: stimulus queues expected tx elements and rx results,
// a negedge monitor pops/compares and tracks a transaction-level model of busy/done/rx_ready.
module tb_fc_stream_host;
    localparam int WIDTH = 16;
    localparam int N     = 6;
    localparam int M     = 8;
    localparam int AW    = $clog2(N);
    localparam int RW    = $clog2(M);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset = 1'b1;
    logic                 load_en = 1'b0;
    logic [AW-1:0]        load_addr = '0;
    logic [WIDTH-1:0]     load_data = '0;
    logic                 start = 1'b0;
    logic                 stall_tx = 1'b0;
    logic                 stall_rx = 1'b0;
    logic                 tx_valid;
    logic                 tx_ready = 1'b0;
    logic [WIDTH-1:0]     tx_data;
    logic                 rx_valid = 1'b0;
    logic                 rx_ready;
    logic [WIDTH-1:0]     rx_data = '0;
    logic [RW-1:0]        rd_addr = '0;
    logic [WIDTH-1:0]     rd_data;
    logic                 busy;
    logic                 done;

    fc_stream_host #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall_tx(stall_tx), .stall_rx(stall_rx),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] vec_m [N];
    logic [WIDTH-1:0] exp_tx [$];
    logic [WIDTH-1:0] rx_src [$];
    logic [WIDTH-1:0] rx_exp [$];

    // transaction-level model state
    bit busy_m = 0, done_m = 0, mon_ok = 0, coincide = 0;
    int tx_seen = 0, rx_seen = 0, cyc = 0, tx_first = 0, tx_last = 0;

    // driver modes
    int tx_mode = 0, stx_mode = 0, srx_mode = 0, rx_mode = 0;
    bit tx_ready_cmd = 0, noise = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare against the model, then advance the model by this cycle's handshakes
    initial begin : monitor
        bit prev_hold = 0;
        bit tx_f, rx_f;
        logic [WIDTH-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_ok) begin
                chk("done", done, done_m);
                chk("busy", busy, busy_m);
                chk("rx_ready", rx_ready, busy_m && (rx_seen < M) && !stall_rx);
                if (!busy_m) chk("tx_valid_idle", tx_valid, 0);
                if (prev_hold) begin
                    chk("tx_hold_valid", tx_valid, 1);
                    chk("tx_hold_data", tx_data, prev_data);
                end
            end
            prev_hold = mon_ok && !reset && tx_valid && !tx_ready;
            prev_data = tx_data;
            tx_f = tx_valid && tx_ready;
            rx_f = rx_valid && rx_ready;
            if (reset) begin
                busy_m = 0; done_m = 0; tx_seen = 0; rx_seen = 0; mon_ok = 1;
            end else if (mon_ok) begin
                if (start && !busy_m) begin
                    busy_m = 1; done_m = 0; tx_seen = 0; rx_seen = 0; coincide = 0;
                end else if (busy_m) begin
                    if (tx_f) begin
                        if (exp_tx.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL tx_extra actual=%0h required=no transfer", tx_data);
                        end else begin
                            chk("tx_data", tx_data, exp_tx.pop_front());
                        end
                        if (tx_seen == 0) tx_first = cyc;
                        tx_last = cyc;
                        tx_seen++;
                    end
                    if (rx_f) rx_seen++;
                    if (tx_seen == N && rx_seen == M) begin
                        busy_m = 0; done_m = 1; coincide = tx_f && rx_f;
                    end
                end else if (tx_f) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected actual=transfer required=none");
                end
            end
        end
    end

    // Handshake driver for tx_ready, stalls and the rx source stream
    initial begin : driver
        bit fired;
        forever begin
            @(negedge clk);
            fired = rx_valid && rx_ready && !reset;
            @(posedge clk); #1;
            if (fired && rx_src.size() > 0) void'(rx_src.pop_front());
            tx_ready = (tx_mode == 0) ? tx_ready_cmd : 1'($urandom_range(0, 1));
            case (stx_mode)
                1:       stall_tx = ~stall_tx;
                2:       stall_tx = ($urandom_range(0, 3) == 0);
                default: stall_tx = 1'b0;
            endcase
            stall_rx = (srx_mode != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            rx_valid = 1'b0;
            rx_data  = WIDTH'($urandom);
            if (rx_mode != 0 && rx_src.size() > 0) begin
                rx_valid = (rx_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                rx_data  = rx_src[0];
            end else if (rx_mode == 2) begin
                rx_valid = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_vec();
        for (int i = 0; i < N; i++) begin
            load_en = 1'b1; load_addr = AW'(i); load_data = vec_m[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic fill_rx(input int base);
        logic [WIDTH-1:0] v;
        rx_exp.delete();
        for (int i = 0; i < M; i++) begin
            v = (base >= 0) ? WIDTH'(base + i) : WIDTH'($urandom);
            rx_src.push_back(v);
            rx_exp.push_back(v);
        end
    endtask

    task automatic do_start();
        for (int i = 0; i < N; i++) exp_tx.push_back(vec_m[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            tick();
            load_en = 1'b0; start = 1'b0;
            if (done_m) return;
            if (noise && busy_m) begin
                load_en   = 1'($urandom_range(0, 1));
                load_addr = AW'($urandom_range(0, N - 1));
                load_data = WIDTH'($urandom);
                start     = ($urandom_range(0, 7) == 0);
            end
        end
        load_en = 1'b0; start = 1'b0;
        checks++; errors++;
        $display("FAIL %s_timeout actual=done_not_reached required=done", tag);
    endtask

    task automatic wait_cnt(input string tag, input bit use_rx, input int n);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if ((use_rx ? rx_seen : tx_seen) >= n) return;
        end
        checks++; errors++;
        $display("FAIL %s_timeout actual=count_not_reached required=%0d", tag, n);
    endtask

    task automatic read_back(input string tag);
        for (int a = 0; a < (1 << RW); a++) begin
            rd_addr = RW'(a);
            #1;
            chk(tag, rd_data, (a < M) ? 32'(rx_exp[a]) : 32'd0);
        end
    endtask

    task automatic rand_vec();
        for (int i = 0; i < N; i++) vec_m[i] = WIDTH'($urandom);
    endtask

    initial begin : stimulus
        int t1 [N] = '{1, -2, 3, -4, 5, -6};
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rx_ready", rx_ready, 0);

        // streaming at full rate, then results 10..17 in RECV
        for (int i = 0; i < N; i++) vec_m[i] = WIDTH'(t1[i]);
        tx_mode = 0; tx_ready_cmd = 1; stx_mode = 0; srx_mode = 0; rx_mode = 0;
        load_vec();
        fill_rx(10);
        do_start();
        wait_cnt("t1_tx", 0, N);
        chk("t1_consecutive", tx_last - tx_first, N - 1);
        tick();
        chk("t1_recv_busy", busy, 1);
        rx_mode = 1;
        wait_done("t1");
        read_back("t1_rd_data");

        // tx_ready held low for three cycles mid-vector
        rand_vec(); load_vec();
        rx_mode = 2; fill_rx(-1);
        do_start();
        wait_cnt("t2_tx", 0, 2);
        tx_ready_cmd = 0;
        repeat (3) tick();
        @(negedge clk); #1;
        tx_ready_cmd = 1;
        wait_done("t2");
        read_back("t2_rd_data");

        // stall_tx toggling every cycle
        rand_vec(); load_vec();
        stx_mode = 1; rx_mode = 1; fill_rx(-1);
        do_start();
        wait_done("t3");
        read_back("t3_rd_data");
        stx_mode = 0;

        // last tx coincides with the M-th rx
        rand_vec(); load_vec();
        tx_ready_cmd = 0; rx_mode = 1; fill_rx(-1);
        tick(); tick();
        do_start();
        wait_cnt("t4_rx", 1, M - N);
        tx_ready_cmd = 1;
        wait_done("t4");
        chk("t4_coincide", coincide, 1);
        read_back("t4_rd_data");

        // reset after three transfers aborts; a new run resends from element 0
        rand_vec(); load_vec();
        rx_mode = 0; fill_rx(-1);
        do_start();
        wait_cnt("t5_tx", 0, 3);
        tick();
        reset = 1'b1;
        exp_tx.delete();
        tick(); tick();
        reset = 1'b0;
        rx_src.delete();
        tick();
        chk("t5_tx_valid", tx_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rx_ready", rx_ready, 0);
        rand_vec(); load_vec();
        rx_mode = 1; fill_rx(-1);
        do_start();
        wait_done("t5");
        read_back("t5_rd_data");

        // randomized runs with throttles and ignored loads/starts while busy
        tx_mode = 1; stx_mode = 2; srx_mode = 1; rx_mode = 2; noise = 1;
        for (int r = 0; r < 8; r++) begin
            rand_vec(); load_vec();
            fill_rx(-1);
            do_start();
            wait_done("rand");
            read_back("rand_rd_data");
        end
        noise = 0;

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
